// File: rtl/csr_access_unit_if.sv
// Bus between the execute stage, the Zicsr sequencer and the machine CSR file.
// The slave modport is the sequencer's view; the master modport is its environment.
interface csr_access_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [11:0]     csr_num;
  logic [4:0]      rs1_idx;
  logic [XLEN-1:0] rs1_val;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            write_en;
  logic [XLEN-1:0] csr_readbus;
  logic            busy;
  logic            done;
  logic            rd_we;
  logic [XLEN-1:0] rd_data;
  logic            illegal;

  modport slave (
    input  start, funct3, csr_num, rs1_idx, rs1_val, rd_idx, csr_readbus,
    output csr_addr, csr_wdata, write_en, busy, done, rd_we, rd_data, illegal
  );

  modport master (
    output start, funct3, csr_num, rs1_idx, rs1_val, rd_idx, csr_readbus,
    input  csr_addr, csr_wdata, write_en, busy, done, rd_we, rd_data, illegal
  );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr sequencer: read the CSR, optionally read-modify-write it, then return
// the old value to the register file with a one-cycle done pulse.
//
// state     | meaning
// S_IDLE    | waiting for start; csr_addr holds last value
// S_READ    | address on the bus, CSR file registers read data
// S_CAPTURE | old value sampled, write data computed
// S_WRITE   | single-cycle write strobe
// S_DONE    | done pulse, rd_we/rd_data/illegal valid
module csr_access_unit #(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              resetn,
  csr_access_unit_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [11:0]     csr_num_q, csr_num_d;
  logic [4:0]      rd_idx_q, rd_idx_d;
  logic [XLEN-1:0] src_q, src_d;
  logic [XLEN-1:0] old_q, old_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            do_write_q, do_write_d;
  logic            illegal_q, illegal_d;

  logic            accept;
  logic            acc_do_write;
  logic            acc_illegal;
  logic [XLEN-1:0] acc_src;

  assign accept       = (state_q == S_IDLE) && bus.start;
  assign acc_do_write = (bus.funct3[1:0] == 2'b01) || (bus.rs1_idx != 5'd0);
  // funct3 000 and 100 both decode to op 00; read-only CSRs trap on any write
  assign acc_illegal  = (bus.funct3[1:0] == 2'b00) ||
                        ((bus.csr_num[11:10] == 2'b11) && acc_do_write);
  assign acc_src      = bus.funct3[2] ? XLEN'(bus.rs1_idx) : bus.rs1_val;

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = S_READ;
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = (do_write_q && !illegal_q) ? S_WRITE : S_DONE;
      S_WRITE:   state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d       = op_q;
    csr_num_d  = csr_num_q;
    rd_idx_d   = rd_idx_q;
    src_d      = src_q;
    do_write_d = do_write_q;
    illegal_d  = illegal_q;
    old_d      = old_q;
    wdata_d    = wdata_q;
    if (accept) begin
      op_d       = bus.funct3[1:0];
      csr_num_d  = bus.csr_num;
      rd_idx_d   = bus.rd_idx;
      src_d      = acc_src;
      do_write_d = acc_do_write;
      illegal_d  = acc_illegal;
    end
    // write data is formed straight from the read bus so WRITE drives a flop
    if (state_q == S_CAPTURE) begin
      old_d = bus.csr_readbus;
      case (op_q)
        2'b10:   wdata_d = bus.csr_readbus | src_q;
        2'b11:   wdata_d = bus.csr_readbus & ~src_q;
        default: wdata_d = src_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_q       <= 2'b00;
      csr_num_q  <= 12'h000;
      rd_idx_q   <= 5'd0;
      src_q      <= '0;
      do_write_q <= 1'b0;
      illegal_q  <= 1'b0;
      old_q      <= '0;
      wdata_q    <= '0;
    end else begin
      op_q       <= op_d;
      csr_num_q  <= csr_num_d;
      rd_idx_q   <= rd_idx_d;
      src_q      <= src_d;
      do_write_q <= do_write_d;
      illegal_q  <= illegal_d;
      old_q      <= old_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.write_en  = (state_q == S_WRITE);
    bus.done      = (state_q == S_DONE);
    bus.rd_we     = (state_q == S_DONE) && (rd_idx_q != 5'd0) && !illegal_q;
    bus.illegal   = (state_q == S_DONE) && illegal_q;
    bus.csr_addr  = XLEN'({csr_num_q, 2'b00});
    bus.csr_wdata = wdata_q;
    bus.rd_data   = old_q;
  end
endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: a CSR file model answers the bus,
// and each instruction is predicted from the Zicsr rules.
module tb_csr_access_unit;
  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_err;

  csr_access_unit_if #(.XLEN(32)) bus ();

  csr_access_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file model: registered read data, write on write_en, bench preload port
  logic [31:0] csr_mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_val;
  logic [31:0] last_wdata;

  always @(posedge clk) begin
    bus.csr_readbus <= csr_mem[bus.csr_addr[13:2]];
    if (pre_we) csr_mem[pre_addr] <= pre_val;
    else if (bus.write_en) csr_mem[bus.csr_addr[13:2]] <= bus.csr_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic preset(input logic [11:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_val = v;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [11:0] cn, input logic [4:0] ri,
                       input logic [31:0] rv, input logic [4:0] rd, input bit pulse_in_write);
    logic [31:0] old_v, src, nv, exp_addr;
    bit dw, ill, wr;
    int n_we, we_cyc, done_cyc, exp_done_cyc;
    logic [31:0] we_data, we_addr, d_rdata;
    logic d_rdwe, d_ill;
    old_v    = csr_mem[cn];
    src      = f3[2] ? {27'b0, ri} : rv;
    dw       = (f3 == 3'b001) || (f3 == 3'b101) || (ri != 5'd0);
    ill      = (f3 == 3'b000) || (f3 == 3'b100) || ((cn >= 12'hC00) && dw);
    wr       = dw && !ill;
    exp_addr = 32'(cn) * 4;
    case (f3)
      3'b001, 3'b101: nv = src;
      3'b010, 3'b110: nv = old_v | src;
      3'b011, 3'b111: nv = old_v & ~src;
      default:        nv = old_v;
    endcase
    exp_done_cyc = wr ? 4 : 3;
    n_we = 0; we_cyc = 0; done_cyc = 0;
    we_data = '0; we_addr = '0; d_rdata = '0; d_rdwe = 1'b0; d_ill = 1'b0;

    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f3; bus.csr_num = cn;
    bus.rs1_idx = ri; bus.rs1_val = rv; bus.rd_idx = rd;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.rs1_val = $urandom;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("busy", {31'b0, bus.busy}, 32'd1);
      if (c == 1) chk("read_addr", bus.csr_addr, exp_addr);
      if (bus.write_en) begin
        n_we++; we_cyc = c; we_data = bus.csr_wdata; we_addr = bus.csr_addr;
      end
      if (pulse_in_write && c == 3) bus.start = 1'b1;
      if (c == 4) bus.start = 1'b0;
      if (bus.done) begin
        done_cyc = c; d_rdata = bus.rd_data; d_rdwe = bus.rd_we; d_ill = bus.illegal;
        chk("done_addr", bus.csr_addr, exp_addr);
        chk("we_with_done", {31'b0, bus.write_en}, 32'd0);
        break;
      end
    end
    bus.start = 1'b0;
    chk("done_cycle", done_cyc, exp_done_cyc);
    chk("we_count", n_we, wr ? 1 : 0);
    if (wr) begin
      chk("we_cycle", we_cyc, 3);
      chk("wdata", we_data, nv);
      chk("we_addr", we_addr, exp_addr);
      last_wdata = we_data;
    end
    chk("rd_data", d_rdata, old_v);
    chk("rd_we", {31'b0, d_rdwe}, {31'b0, (rd != 5'd0) && !ill});
    chk("illegal", {31'b0, d_ill}, {31'b0, ill});
    chk("csr_after", csr_mem[cn], wr ? nv : old_v);
  endtask

  initial begin
    int extra;
    n_cmp = 0; n_err = 0;
    resetn = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_val = '0; last_wdata = '0;
    bus.start = 1'b0; bus.funct3 = '0; bus.csr_num = '0;
    bus.rs1_idx = '0; bus.rs1_val = '0; bus.rd_idx = '0;
    for (int i = 0; i < 4096; i++) csr_mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_we", {31'b0, bus.write_en}, 32'd0);
    chk("rst_rdwe", {31'b0, bus.rd_we}, 32'd0);
    chk("rst_illegal", {31'b0, bus.illegal}, 32'd0);
    chk("rst_addr", bus.csr_addr, 32'd0);
    chk("rst_wdata", bus.csr_wdata, 32'd0);
    chk("rst_rdata", bus.rd_data, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // directed cases
    preset(12'h340, 32'h12345678);
    issue(3'b001, 12'h340, 5'd1, 32'hDEADBEEF, 5'd5, 1'b0);
    chk("t1_wdata", last_wdata, 32'hDEADBEEF);
    preset(12'h300, 32'h00001800);
    issue(3'b010, 12'h300, 5'd6, 32'h00000008, 5'd7, 1'b0);
    chk("rs_wdata", last_wdata, 32'h00001808);
    issue(3'b011, 12'h300, 5'd6, 32'h00000800, 5'd7, 1'b0);
    chk("rc_wdata", last_wdata, 32'h00001008);
    preset(12'hF11, 32'hCAFEF00D);
    issue(3'b010, 12'hF11, 5'd0, 32'hFFFFFFFF, 5'd3, 1'b0);
    issue(3'b101, 12'hC00, 5'd4, 32'h0, 5'd2, 1'b0);
    issue(3'b100, 12'h305, 5'd9, 32'h55, 5'd2, 1'b0);
    preset(12'h304, 32'hFFFFFFFF);
    issue(3'b111, 12'h304, 5'h1F, 32'h0, 5'd8, 1'b0);
    chk("rci_wdata", last_wdata, 32'hFFFFFFE0);

    // start pulsed during WRITE must not queue a second instruction
    issue(3'b001, 12'h342, 5'd2, 32'h0BADF00D, 5'd4, 1'b1);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra++;
    end
    chk("no_extra_op", extra, 0);

    // reset asserted during CAPTURE aborts the instruction
    preset(12'h341, 32'hAAAA5555);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b001; bus.csr_num = 12'h341;
    bus.rs1_idx = 5'd1; bus.rs1_val = 32'h1; bus.rd_idx = 5'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_capture_busy", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_we", {31'b0, bus.write_en}, 32'd0);
    chk("abort_done", {31'b0, bus.done}, 32'd0);
    chk("abort_addr", bus.csr_addr, 32'd0);
    chk("abort_rdata", bus.rd_data, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done || bus.write_en) extra++;
    end
    chk("abort_quiet", extra, 0);
    chk("abort_csr", csr_mem[12'h341], 32'hAAAA5555);

    // randomized instructions, issued back to back
    for (int k = 0; k < 40; k++) begin
      logic [11:0] cn;
      logic [4:0]  ri, rd;
      cn = 12'($urandom_range(0, 4095));
      ri = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      if (k % 8 == 0) preset(cn, $urandom);
      issue(3'($urandom), cn, ri, $urandom, rd, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
